demux_vc: RTL and testbench
===========================

# demux_vc

Parametrised N-way virtual-channel demultiplexer between the shared ingress FIFO and the per-VC FIFOs. It pops words from the ingress FIFO and extracts the VC ID from the top ID_W bits of each word. It writes each word to the addressed VC FIFO on a shared registered data bus with a one-hot write strobe. Per-VC almost-full backpressure is honoured: a word bound for a paused VC is parked in a hold register and ingress reads stop until that VC drains. It also keeps a free-running per-VC word count.

## Interface
- BITNUMBER, 6: word width; VC ID occupies bits [BITNUMBER-1 -: ID_W].
- NUM_VC, 2: number of virtual channels; power of two, ≥2.
- CNT_W, 8: width of each per-VC word counter.
- ID_W (localparam), $clog2(NUM_VC): VC ID field width.
- clk  in  1  clock, all logic on rising edge.
- reset_L  in  1  synchronous, active-low reset.
- fifo_data_out  in  BITNUMBER  ingress FIFO read data, valid the cycle after fifo_rd.
- fifo_empty  in  1  ingress FIFO empty.
- vc_pause  in  NUM_VC  per-VC almost-full; threshold leaves ≥2 free entries.
- fifo_rd  out  1  ingress pop; combinational.
- demux_data  out  BITNUMBER  registered word to VC FIFOs, shared by all VCs.
- vc_wr  out  NUM_VC  registered one-hot write strobe; at most one bit high.
- stall  out  1  registered; high while in HOLD.
- vc_cnt  out  NUM_VC*CNT_W  words written per VC; VC k in bits [k*CNT_W +: CNT_W].

## Operation
- Internal registers:
  - state ∈ {RUN, HOLD}.
  - rd_pending: fifo_rd delayed one cycle.
  - hold_word and hold_id.
- Arriving ID: id = fifo_data_out[BITNUMBER-1 -: ID_W].
- Reset (reset_L=0 at an edge): state=RUN, rd_pending=0, hold_word=0, demux_data=0, vc_wr=0, stall=0, all vc_cnt=0. fifo_rd is forced 0 while reset_L=0.
- fifo_rd = reset_L & !fifo_empty & (RUN ? !(rd_pending & vc_pause[id]) : !vc_pause[hold_id]).
- RUN with rd_pending=1:
  - If vc_pause[id]=0: next edge demux_data←fifo_data_out, vc_wr←onehot(id), vc_cnt[id]+1.
  - If vc_pause[id]=1: hold_word←fifo_data_out, hold_id←id, vc_wr←0, state←HOLD.
- RUN with rd_pending=0: vc_wr←0; demux_data keeps its last value.
- HOLD with vc_pause[hold_id]=1: vc_wr←0, nothing popped.
- HOLD with vc_pause[hold_id]=0: next edge writes hold_word to hold_id, increments its counter, state←RUN. A new pop may be issued in the same cycle; its data arrives in RUN.
- Pauses on VCs other than the addressed one have no effect; there is no reordering and no bypass of the held word (head-of-line blocking is accepted).
- Counters wrap modulo 2^CNT_W without a flag.
- ID values ≥ NUM_VC cannot occur because NUM_VC is a power of two.
- Reset mid-operation discards the held word and any in-flight read; the ingress FIFO owner accepts that loss.

## Timing
- Latency: fifo_rd at edge t → data on fifo_data_out during t+1 → vc_wr/demux_data valid after edge t+2.
- Throughput: one word per cycle while the ingress FIFO is non-empty and targets are unpaused.
- Pause reaction: a pause seen on the arriving word's VC blocks the pop in that same cycle. At most one word is committed beyond the pause, so the 2-entry margin suffices.
- Stall release: vc_pause low at cycle c → held word written after edge c+1; stall falls at that edge.
- fifo_empty during rd_pending does not cancel the arriving word.

## Structure
- Shared package (demux_vc_pkg / defines header):
  - state encodings (RUN=0, HOLD=1);
  - default CNT_W;
  - ID-field extraction macro, shared with the VC arbiter/mux side.
- One sub-module: vc_word_counter, a NUM_VC×CNT_W counter bank with sync active-low reset, a one-hot increment input and a flattened output.
- Everything else (FSM, hold register, fifo_rd logic, onehot decode) lives in demux_vc.

## Test plan
- NUM_VC=2, BITNUMBER=6, push 0x05, 0x25, 0x07, no pauses. Required: vc_wr = 01, 10, 01 on consecutive cycles starting 2 cycles after the first fifo_rd; vc_cnt = {1,2}.
- NUM_VC=4, BITNUMBER=8, stream 0x00, 0x40, 0x80, 0xC0. Required: vc_wr = 0001, 0010, 0100, 1000 back-to-back; each counter = 1.
- NUM_VC=2, vc_pause[1]=1, push 0x25 then 0x03. Required:
  - 0x25 is held, stall=1, fifo_rd=0, and 0x03 is not popped.
  - Drop vc_pause[1]: vc_wr=10 with data 0x25, then vc_wr=01 with data 0x03.
- Pause VC0 while a stream targets VC1 only. Required: no stall, full rate, vc_cnt[0] unchanged.
- CNT_W=2, send 5 words to VC0. Required: vc_cnt[0]=1 (wrapped).
- Assert reset_L=0 while in HOLD. Required:
  - Next edge: stall=0, vc_wr=0, vc_cnt=0, fifo_rd=0 during reset.
  - The held word is never written.

Source files
------------

// File: rtl/demux_vc_pkg.sv
// Definitions shared by the VC demux and the arbiter/mux on the other side of the VC FIFOs.
// Holds the FSM encoding, the default counter width and the VC ID field extraction helper.
package demux_vc_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEFAULT_CNT_W = 8;
    localparam int MAX_WORD_W    = 64;

    // VC ID sits in the top idw bits of a w-bit word; callers zero-extend the word to MAX_WORD_W.
    function automatic logic [31:0] vc_id(input logic [MAX_WORD_W-1:0] word, input int w, input int idw);
        logic [MAX_WORD_W-1:0] mask;
        mask  = (MAX_WORD_W'(1) << idw) - MAX_WORD_W'(1);
        vc_id = 32'((word >> (w - idw)) & mask);
    endfunction

endpackage

// File: rtl/vc_word_counter.sv
// Bank of NUM_VC free-running word counters, one increment strobe bit per VC.
// Latency: count updates on the edge that samples inc. No backpressure; counters wrap silently.
// Backpressure: none.
module vc_word_counter
    import demux_vc_pkg::*;
#(
    parameter int NUM_VC = 2,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic [NUM_VC-1:0]       inc,
    output logic [NUM_VC*CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            cnt <= '0;
        end else begin
            for (int k = 0; k < NUM_VC; k++) begin
                if (inc[k]) begin
                    cnt[k*CNT_W +: CNT_W] <= cnt[k*CNT_W +: CNT_W] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/demux_vc.sv
// Steers words from the shared ingress FIFO to per-VC FIFOs by the VC ID in each word's top bits.
// Latency: pop at cycle t, word on demux_data/vc_wr after edge t+2; one word per cycle sustained.
// Backpressure: a word for a paused VC is parked in a hold register and popping stops until it drains.
module demux_vc
    import demux_vc_pkg::*;
#(
    parameter int  BITNUMBER = 6,
    parameter int  NUM_VC    = 2,
    parameter int  CNT_W     = DEFAULT_CNT_W,
    localparam int ID_W      = $clog2(NUM_VC)
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic [BITNUMBER-1:0]    fifo_data_out,
    input  logic                    fifo_empty,
    input  logic [NUM_VC-1:0]       vc_pause,
    output logic                    fifo_rd,
    output logic [BITNUMBER-1:0]    demux_data,
    output logic [NUM_VC-1:0]       vc_wr,
    output logic                    stall,
    output logic [NUM_VC*CNT_W-1:0] vc_cnt
);

    state_t                state, state_n;
    logic                  rd_pending;
    logic [BITNUMBER-1:0]  hold_word, hold_word_n;
    logic [ID_W-1:0]       hold_id, hold_id_n;
    logic [ID_W-1:0]       id;
    logic [BITNUMBER-1:0]  data_n;
    logic [NUM_VC-1:0]     wr_n;

    assign id = ID_W'(vc_id(MAX_WORD_W'(fifo_data_out), BITNUMBER, ID_W));

    // The arriving word's own pause blocks the next pop in the same cycle, so at most one
    // word ever lands past a pause and it ends up in the hold register.
    always_comb begin
        fifo_rd = 1'b0;
        if (reset_L && !fifo_empty) begin
            if (state == RUN) begin
                fifo_rd = !(rd_pending && vc_pause[id]);
            end else begin
                fifo_rd = !vc_pause[hold_id];
            end
        end
    end

    always_comb begin
        state_n     = state;
        hold_word_n = hold_word;
        hold_id_n   = hold_id;
        data_n      = demux_data;
        wr_n        = '0;
        case (state)
            RUN: begin
                if (rd_pending) begin
                    if (!vc_pause[id]) begin
                        data_n   = fifo_data_out;
                        wr_n[id] = 1'b1;
                    end else begin
                        hold_word_n = fifo_data_out;
                        hold_id_n   = id;
                        state_n     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!vc_pause[hold_id]) begin
                    data_n        = hold_word;
                    wr_n[hold_id] = 1'b1;
                    state_n       = RUN;
                end
            end
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state      <= RUN;
            rd_pending <= 1'b0;
            hold_word  <= '0;
            hold_id    <= '0;
            demux_data <= '0;
            vc_wr      <= '0;
            stall      <= 1'b0;
        end else begin
            state      <= state_n;
            rd_pending <= fifo_rd;
            hold_word  <= hold_word_n;
            hold_id    <= hold_id_n;
            demux_data <= data_n;
            vc_wr      <= wr_n;
            stall      <= (state_n == HOLD);
        end
    end

    vc_word_counter #(
        .NUM_VC (NUM_VC),
        .CNT_W  (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .reset_L (reset_L),
        .inc     (wr_n),
        .cnt     (vc_cnt)
    );

endmodule

// File: tb/tb_demux_vc.sv
// Directed bench: two demux_vc configurations (2 VC x 6 bit x 8-bit counters, 4 VC x 8 bit x 2-bit
// counters) fed by simple ingress FIFO models; stream vectors from a table plus hold/reset sequences.
module tb_demux_vc;

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    always #5 clk = ~clk;

    // Instance A: NUM_VC=2, BITNUMBER=6, CNT_W=8
    logic [5:0]  a_fifo_data_out = '0;
    logic        a_fifo_empty;
    logic [1:0]  a_vc_pause = '0;
    logic        a_fifo_rd;
    logic [5:0]  a_demux_data;
    logic [1:0]  a_vc_wr;
    logic        a_stall;
    logic [15:0] a_vc_cnt;
    logic [5:0]  a_mem [64];
    logic [5:0]  a_rp = '0;
    logic [5:0]  a_wp = '0;

    // Instance B: NUM_VC=4, BITNUMBER=8, CNT_W=2
    logic [7:0]  b_fifo_data_out = '0;
    logic        b_fifo_empty;
    logic [3:0]  b_vc_pause = '0;
    logic        b_fifo_rd;
    logic [7:0]  b_demux_data;
    logic [3:0]  b_vc_wr;
    logic        b_stall;
    logic [7:0]  b_vc_cnt;
    logic [7:0]  b_mem [64];
    logic [5:0]  b_rp = '0;
    logic [5:0]  b_wp = '0;

    demux_vc #(.BITNUMBER(6), .NUM_VC(2), .CNT_W(8)) u_a (
        .clk(clk), .reset_L(reset_L), .fifo_data_out(a_fifo_data_out), .fifo_empty(a_fifo_empty),
        .vc_pause(a_vc_pause), .fifo_rd(a_fifo_rd), .demux_data(a_demux_data), .vc_wr(a_vc_wr),
        .stall(a_stall), .vc_cnt(a_vc_cnt)
    );

    demux_vc #(.BITNUMBER(8), .NUM_VC(4), .CNT_W(2)) u_b (
        .clk(clk), .reset_L(reset_L), .fifo_data_out(b_fifo_data_out), .fifo_empty(b_fifo_empty),
        .vc_pause(b_vc_pause), .fifo_rd(b_fifo_rd), .demux_data(b_demux_data), .vc_wr(b_vc_wr),
        .stall(b_stall), .vc_cnt(b_vc_cnt)
    );

    // Ingress FIFO models: read data appears the cycle after fifo_rd.
    assign a_fifo_empty = (a_rp == a_wp);
    assign b_fifo_empty = (b_rp == b_wp);

    always @(posedge clk) begin
        if (a_fifo_rd) begin
            a_fifo_data_out <= a_mem[a_rp];
            a_rp <= a_rp + 6'd1;
        end
        if (b_fifo_rd) begin
            b_fifo_data_out <= b_mem[b_rp];
            b_rp <= b_rp + 6'd1;
        end
    end

    // Observation mux so one checker serves both instances.
    logic        sel_b = 1'b0;
    logic [3:0]  obs_wr;
    logic [7:0]  obs_dat;
    logic [15:0] obs_cnt;
    logic        obs_rd;
    logic        obs_stall;

    always_comb begin
        if (sel_b) begin
            obs_wr    = b_vc_wr;
            obs_dat   = b_demux_data;
            obs_cnt   = {8'h00, b_vc_cnt};
            obs_rd    = b_fifo_rd;
            obs_stall = b_stall;
        end else begin
            obs_wr    = {2'b00, a_vc_wr};
            obs_dat   = {2'b00, a_demux_data};
            obs_cnt   = a_vc_cnt;
            obs_rd    = a_fifo_rd;
            obs_stall = a_stall;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] w);
        if (sel_b) begin
            b_mem[b_wp] = w;
            b_wp = b_wp + 6'd1;
        end else begin
            a_mem[a_wp] = w[5:0];
            a_wp = a_wp + 6'd1;
        end
    endtask

    task automatic set_pause(input logic [3:0] p);
        a_vc_pause = sel_b ? 2'b00 : p[1:0];
        b_vc_pause = sel_b ? p : 4'b0000;
    endtask

    // Reset with empty ingress and no pauses; checks the reset state of the selected instance.
    task automatic do_reset(input string tag);
        reset_L = 1'b0;
        set_pause(4'b0000);
        tick();
        tick();
        chk({tag, " reset vc_wr"}, {12'h0, obs_wr}, 16'h0);
        chk({tag, " reset stall"}, {15'h0, obs_stall}, 16'h0);
        chk({tag, " reset vc_cnt"}, obs_cnt, 16'h0);
        chk({tag, " reset demux_data"}, {8'h0, obs_dat}, 16'h0);
        chk({tag, " reset fifo_rd"}, {15'h0, obs_rd}, 16'h0);
        a_wp = a_rp;
        b_wp = b_rp;
    endtask

    typedef struct packed {
        logic            sel_b;
        logic [2:0]      n;
        logic [3:0]      pause;
        logic [4:0][7:0] w;
        logic [4:0][3:0] wr;
        logic [15:0]     cnt;
    } vec_t;

    vec_t tv [4];

    task automatic run_case(input int i);
        bit found;
        string tag;
        tag = $sformatf("case%0d", i);
        sel_b = tv[i].sel_b;
        do_reset(tag);
        for (int k = 0; k < int'(tv[i].n); k++) load(tv[i].w[k]);
        set_pause(tv[i].pause);
        reset_L = 1'b1;
        #1;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (obs_rd) begin
                found = 1'b1;
                break;
            end
            tick();
            #1;
        end
        chk({tag, " first fifo_rd seen"}, {15'h0, found}, 16'h1);
        tick();
        tick();
        for (int k = 0; k < int'(tv[i].n); k++) begin
            chk($sformatf("%s vc_wr[%0d]", tag, k), {12'h0, obs_wr}, {12'h0, tv[i].wr[k]});
            chk($sformatf("%s demux_data[%0d]", tag, k), {8'h0, obs_dat},
                sel_b ? {8'h0, tv[i].w[k]} : {10'h0, tv[i].w[k][5:0]});
            chk($sformatf("%s stall[%0d]", tag, k), {15'h0, obs_stall}, 16'h0);
            if (k < int'(tv[i].n) - 1) tick();
        end
        tick();
        tick();
        chk({tag, " idle vc_wr"}, {12'h0, obs_wr}, 16'h0);
        chk({tag, " final vc_cnt"}, obs_cnt, tv[i].cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        logic [5:0] base;

        // 2 VC: 0x05 -> VC0, 0x25 -> VC1, 0x07 -> VC0
        tv[0] = '{sel_b: 1'b0, n: 3'd3, pause: 4'b0000,
                  w:  {8'h00, 8'h00, 8'h07, 8'h25, 8'h05},
                  wr: {4'h0, 4'h0, 4'h1, 4'h2, 4'h1}, cnt: 16'h0102};
        // 4 VC: one word to each VC back-to-back
        tv[1] = '{sel_b: 1'b1, n: 3'd4, pause: 4'b0000,
                  w:  {8'h00, 8'hC0, 8'h80, 8'h40, 8'h00},
                  wr: {4'h0, 4'h8, 4'h4, 4'h2, 4'h1}, cnt: 16'h0055};
        // 2 VC: VC0 paused, stream to VC1 only, full rate, VC0 count untouched
        tv[2] = '{sel_b: 1'b0, n: 3'd3, pause: 4'b0001,
                  w:  {8'h00, 8'h00, 8'h3F, 8'h27, 8'h25},
                  wr: {4'h0, 4'h0, 4'h2, 4'h2, 4'h2}, cnt: 16'h0300};
        // 4 VC, 2-bit counters: five words to VC0 wrap its count to 1; other VCs paused
        tv[3] = '{sel_b: 1'b1, n: 3'd5, pause: 4'b1110,
                  w:  {8'h04, 8'h03, 8'h02, 8'h01, 8'h00},
                  wr: {4'h1, 4'h1, 4'h1, 4'h1, 4'h1}, cnt: 16'h0001};

        tick();
        for (int i = 0; i < 4; i++) run_case(i);

        // Hold and release: 0x25 parks while VC1 is paused, 0x03 waits behind it.
        sel_b = 1'b0;
        do_reset("hold");
        base = a_rp;
        load(8'h25);
        load(8'h03);
        set_pause(4'b0010);
        reset_L = 1'b1;
        #1;
        chk("hold first pop", {15'h0, a_fifo_rd}, 16'h1);
        tick();
        chk("hold pop blocked on arrival", {15'h0, a_fifo_rd}, 16'h0);
        tick();
        chk("hold stall", {15'h0, a_stall}, 16'h1);
        chk("hold vc_wr idle", {14'h0, a_vc_wr}, 16'h0);
        tick();
        tick();
        chk("hold stall steady", {15'h0, a_stall}, 16'h1);
        chk("hold fifo_rd low", {15'h0, a_fifo_rd}, 16'h0);
        chk("hold second word not popped", {10'h0, 6'(a_rp - base)}, 16'h1);
        set_pause(4'b0000);
        #1;
        chk("release pop issued", {15'h0, a_fifo_rd}, 16'h1);
        tick();
        chk("release vc_wr", {14'h0, a_vc_wr}, 16'h2);
        chk("release data", {10'h0, a_demux_data}, 16'h25);
        chk("release stall", {15'h0, a_stall}, 16'h0);
        tick();
        chk("next vc_wr", {14'h0, a_vc_wr}, 16'h1);
        chk("next data", {10'h0, a_demux_data}, 16'h03);
        tick();
        chk("after release vc_wr", {14'h0, a_vc_wr}, 16'h0);
        chk("after release vc_cnt", a_vc_cnt, 16'h0101);

        // Reset while holding: the parked word must be discarded.
        do_reset("rsthold");
        load(8'h25);
        set_pause(4'b0010);
        reset_L = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (a_stall) begin
                found = 1'b1;
                break;
            end
        end
        chk("rsthold reached HOLD", {15'h0, found}, 16'h1);
        reset_L = 1'b0;
        #1;
        chk("rsthold fifo_rd in reset", {15'h0, a_fifo_rd}, 16'h0);
        tick();
        chk("rsthold stall", {15'h0, a_stall}, 16'h0);
        chk("rsthold vc_wr", {14'h0, a_vc_wr}, 16'h0);
        chk("rsthold vc_cnt", a_vc_cnt, 16'h0);
        set_pause(4'b0000);
        tick();
        reset_L = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("rsthold no write %0d", c), {14'h0, a_vc_wr}, 16'h0);
        end
        chk("rsthold vc_cnt end", a_vc_cnt, 16'h0);
        chk("rsthold data end", {10'h0, a_demux_data}, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
